brightness_frame_ctrl: RTL and testbench

Sequencer and scheduler for the per-pixel brightness datapath.
- On a start command it scans one frame of HEIGHT x WIDTH RGB pixels from the image buffer in raster order.
- Each pixel gets a saturating brightness offset (increase or decrease).
- Adjusted pixels are streamed out on a valid/ready interface with frame/line markers.
- It sits between the image-buffer read port and downstream display/writeback logic, and owns all addressing, flow control and per-frame configuration.

---
 rtl/brightness_frame_ctrl_pkg.sv | 46 ++++
 rtl/brightness_frame_ctrl_fifo2.sv | 57 +++++
 rtl/brightness_frame_ctrl.sv | 174 +++++++++++++++++
 tb/tb_brightness_frame_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brightness_frame_ctrl_pkg.sv
// brightness_pkg
//   Shared types and helpers for the brightness frame controller.
//   - pixel_t     : one RGB pixel, 8 bits per channel, {r,g,b}
//   - pix_entry_t : pixel plus frame/line tags as stored in the output FIFO
//   - state_t     : sequencer FSM state encoding
//   - sat_adj()   : saturating per-channel brightness offset
package brightness_pkg;

  localparam logic [7:0] PIX_MAX = 8'd255;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef struct packed {
    pixel_t pix;
    logic   sof;
    logic   eol;
    logic   eof;
  } pix_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // The 9th bit of the intermediate is the carry (add) or borrow (sub),
  // which is exactly the saturation condition.
  function automatic logic [7:0] sat_adj(input logic [7:0] ch,
                                         input logic [7:0] off,
                                         input logic       sub);
    logic [8:0] tmp;
    if (sub) begin
      tmp     = {1'b0, ch} - {1'b0, off};
      sat_adj = tmp[8] ? 8'd0 : tmp[7:0];
    end else begin
      tmp     = {1'b0, ch} + {1'b0, off};
      sat_adj = tmp[8] ? PIX_MAX : tmp[7:0];
    end
  endfunction

endpackage

// File: rtl/brightness_frame_ctrl_fifo2.sv
// pix_fifo2
//   Two-entry FIFO holding adjusted pixels with their sof/eol/eof tags.
//   A push while full is accepted when a pop happens in the same cycle.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     push, din     : write strobe and entry
//     pop           : read strobe (head is consumed at the clock edge)
//     dout          : head entry (combinational view of the read slot)
//     count         : occupancy 0..2
//     full, empty   : occupancy flags
module pix_fifo2
  import brightness_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  pix_entry_t din,
  output pix_entry_t dout,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  pix_entry_t mem [2];
  logic       wptr;
  logic       rptr;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (do_pop) rptr <= ~rptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/brightness_frame_ctrl.sv
// brightness_frame_ctrl
//   Scans one HEIGHT x WIDTH frame from the image buffer in raster order,
//   applies a saturating brightness offset to each pixel and streams the
//   result downstream with frame/line markers.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     start, offset, dec       : frame request and per-frame config (IDLE only)
//     rd_en, rd_addr, rd_data  : image-buffer read port, data one cycle later
//     out_valid, out_ready     : output handshake
//     out_r/g/b, out_sof/eol/eof : head pixel and its tags
//     busy, done               : frame in progress / one-cycle completion pulse
//
//   Handshake: a pixel transfers on every rising edge where out_valid and
//   out_ready are both 1. out_valid never drops and out_* never change while
//   a pixel is offered and not yet accepted; out_ready may change freely.
module brightness_frame_ctrl
  import brightness_pkg::*;
#(
  parameter int HEIGHT = 768,
  parameter int WIDTH  = 512,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        offset,
  input  logic              dec,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_r,
  output logic [7:0]        out_g,
  output logic [7:0]        out_b,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  state_t            state;
  logic [7:0]        off_sh;
  logic              dec_sh;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] addr_q;

  // Read issued last cycle: rd_data is valid now and is pushed this cycle.
  logic              data_vld;
  logic [2:0]        tag_q;

  pix_entry_t        push_entry;
  pix_entry_t        head;
  logic [1:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  logic              last_col;
  logic              last_row;
  logic              pop;
  logic [2:0]        occ;
  logic              issue;

  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);
  assign pop      = !fifo_empty && out_ready;

  // Count what the FIFO will have to hold after this edge: entries that
  // survive this cycle's pop plus the read landing now. A new read is only
  // allowed when there is still a free slot for it, so the FIFO can never
  // overflow even if out_ready drops and stays low.
  assign occ   = 3'(fifo_count) + 3'(data_vld) - 3'(pop);
  assign issue = (state == S_SCAN) && (occ < 3'd2);

  assign rd_en   = issue;
  assign rd_addr = addr_q;

  always_comb begin
    push_entry       = '0;
    push_entry.pix.r = sat_adj(rd_data[23:16], off_sh, dec_sh);
    push_entry.pix.g = sat_adj(rd_data[15:8],  off_sh, dec_sh);
    push_entry.pix.b = sat_adj(rd_data[7:0],   off_sh, dec_sh);
    push_entry.sof   = tag_q[2];
    push_entry.eol   = tag_q[1];
    push_entry.eof   = tag_q[0];
  end

  pix_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_vld),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stale FIFO slots are masked so every output reads 0 while nothing is
  // offered.
  assign out_valid = !fifo_empty;
  assign out_r     = out_valid ? head.pix.r : 8'd0;
  assign out_g     = out_valid ? head.pix.g : 8'd0;
  assign out_b     = out_valid ? head.pix.b : 8'd0;
  assign out_sof   = out_valid && head.sof;
  assign out_eol   = out_valid && head.eol;
  assign out_eof   = out_valid && head.eof;

  assign busy = (state == S_SCAN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      off_sh   <= 8'd0;
      dec_sh   <= 1'b0;
      col      <= '0;
      row      <= '0;
      addr_q   <= '0;
      data_vld <= 1'b0;
      tag_q    <= 3'b000;
    end else begin
      data_vld <= issue;
      if (issue) begin
        tag_q <= {(row == '0) && (col == '0), last_col, last_row && last_col};
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            off_sh <= offset;
            dec_sh <= dec;
            col    <= '0;
            row    <= '0;
            addr_q <= '0;
            state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (issue) begin
            // The final address is held rather than advanced past the frame.
            if (last_row && last_col) begin
              state <= S_DRAIN;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
              if (last_col) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          if (pop && head.eof) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brightness_frame_ctrl.sv
// tb_brightness_frame_ctrl
//   Bench for brightness_frame_ctrl: a 4-wide x 3-row instance driven with
//   random images, offsets and out_ready patterns, plus a 1x1 instance.
module tb_brightness_frame_ctrl;

  localparam int H  = 3;
  localparam int W  = 4;
  localparam int N  = H * W;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- main DUT (4x3) ----------------
  logic          start = 1'b0;
  logic [7:0]    offset = 8'd0;
  logic          dec = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data = 24'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_r, out_g, out_b;
  logic          out_sof, out_eol, out_eof;
  logic          busy, done;

  brightness_frame_ctrl #(.HEIGHT(H), .WIDTH(W), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .offset(offset), .dec(dec),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .done(done)
  );

  // ---------------- 1x1 DUT ----------------
  logic        start1 = 1'b0;
  logic [7:0]  offset1 = 8'd0;
  logic        dec1 = 1'b0;
  logic        rd_en1;
  logic [0:0]  rd_addr1;
  logic [23:0] rd_data1 = 24'd0;
  logic        out_valid1;
  logic        out_ready1 = 1'b0;
  logic [7:0]  out_r1, out_g1, out_b1;
  logic        out_sof1, out_eol1, out_eof1;
  logic        busy1, done1;

  brightness_frame_ctrl #(.HEIGHT(1), .WIDTH(1), .ADDR_W(1)) u_one (
    .clk(clk), .rst(rst), .start(start1), .offset(offset1), .dec(dec1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_r(out_r1), .out_g(out_g1), .out_b(out_b1),
    .out_sof(out_sof1), .out_eol(out_eol1), .out_eof(out_eof1),
    .busy(busy1), .done(done1)
  );

  // ---------------- image buffers (one-cycle read latency) ----------------
  logic [23:0] img [N];
  logic [23:0] img1 = 24'd0;

  // Off-strobe cycles return junk so the DUT cannot rely on stale data.
  always @(posedge clk) rd_data  <= rd_en  ? img[rd_addr] : 24'($urandom);
  always @(posedge clk) rd_data1 <= rd_en1 ? img1         : 24'($urandom);

  // ---------------- out_ready driver ----------------
  int rdy_mode = 0;   // 0: always ready, 1: ready one cycle in three, 2: random
  int rdy_ph   = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (rdy_ph == 0);
        rdy_ph    = (rdy_ph == 2) ? 0 : rdy_ph + 1;
      end
      default: out_ready = ($urandom_range(0, 99) < 60);
    endcase
  end

  // ---------------- scoreboard state ----------------
  logic [26:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic        in_frame = 1'b0;
  logic        done_pend = 1'b0;
  logic        held_v = 1'b0;
  logic [26:0] held = '0;
  int issued = 0, accepted = 0, nxt_addr = 0;
  int start_cyc = 0, first_valid_cyc = -1, first_acc = 0, last_acc = 0, acc_in_frame = 0;

  logic [26:0] cur;
  assign cur = {out_r, out_g, out_b, out_sof, out_eol, out_eof};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic clamped to the 0..255 pixel range.
  function automatic logic [7:0] ref_ch(input int c, input int o, input bit d);
    int v;
    v = d ? (c - o) : (c + o);
    if (v > 255) v = 255;
    if (v < 0)   v = 0;
    return 8'(v);
  endfunction

  task automatic queue_frame(input int o, input bit d);
    logic [23:0] px;
    for (int a = 0; a < N; a++) begin
      px = img[a];
      exp_q.push_back({ref_ch(int'(px[23:16]), o, d), ref_ch(int'(px[15:8]), o, d),
                       ref_ch(int'(px[7:0]), o, d),
                       (a == 0), ((a % W) == W - 1), (a == N - 1)});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      issued    = 0;
      accepted  = 0;
      held_v    = 1'b0;
      done_pend = 1'b0;
    end else begin
      chk("busy", busy, in_frame);
      chk("done", done, done_pend);
      done_pend = 1'b0;
      if (held_v) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", cur, held);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (rd_en) begin
        chk("rd_addr", rd_addr, nxt_addr);
        nxt_addr++;
        issued++;
      end
      if (out_valid && out_ready) begin
        logic [26:0] e;
        accepted++;
        if (acc_in_frame == 0) first_acc = cyc;
        last_acc = cyc;
        acc_in_frame++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL pixel: got 0x%0h, expected none (cycle %0d)", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          n_cmp--;
          chk("pixel", cur, e);
          if (e[0]) begin
            in_frame  = 1'b0;
            done_pend = 1'b1;
          end
        end
      end
      if (rd_en) begin
        n_cmp++;
        if (issued - accepted > 2) begin
          n_bad++;
          $display("FAIL outstanding: got %0d, expected at most 2 (cycle %0d)", issued - accepted, cyc);
        end
      end
      held_v = out_valid && !out_ready;
      held   = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_img();
    for (int a = 0; a < N; a++) img[a] = 24'($urandom);
  endtask

  task automatic start_frame(input logic [7:0] o, input logic d, input int mode);
    rdy_mode = mode;
    queue_frame(int'(o), d);
    offset = o;
    dec    = d;
    start  = 1'b1;
    @(posedge clk); #1;
    start           = 1'b0;
    in_frame        = 1'b1;
    start_cyc       = cyc;
    nxt_addr        = 0;
    acc_in_frame    = 0;
    first_valid_cyc = -1;
    // Later config changes must not affect the running frame.
    offset = 8'($urandom);
    dec    = 1'($urandom);
  endtask

  task automatic wait_frame(input string nm);
    int k;
    k = 0;
    while (in_frame && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (in_frame) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d pixels pending, expected 0", nm, exp_q.size());
      in_frame = 1'b0;
      exp_q.delete();
    end
    #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({nm, "_leftover"}, exp_q.size(), 0);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_rd_en"}, rd_en, 0);
    chk({nm, "_rd_addr"}, rd_addr, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_rgb"}, {out_r, out_g, out_b}, 0);
    chk({nm, "_tags"}, {out_sof, out_eol, out_eof}, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  task automatic one_frame(input logic [7:0] o, input logic d);
    logic [23:0] px;
    int k, reads;
    logic got;
    px      = 24'($urandom);
    img1    = px;
    offset1 = o;
    dec1    = d;
    out_ready1 = 1'b1;
    start1  = 1'b1;
    @(posedge clk); #1;
    start1  = 1'b0;
    offset1 = ~o;
    reads = 0; got = 1'b0; k = 0;
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      chk("one_busy", busy1, 1);
      if (rd_en1) begin
        reads++;
        chk("one_rd_addr", rd_addr1, 0);
      end
      if (out_valid1) begin
        got = 1'b1;
        chk("one_latency", k, 3);
        chk("one_pixel", {out_r1, out_g1, out_b1, out_sof1, out_eol1, out_eof1},
            {ref_ch(int'(px[23:16]), int'(o), d), ref_ch(int'(px[15:8]), int'(o), d),
             ref_ch(int'(px[7:0]), int'(o), d), 3'b111});
      end
    end
    chk("one_got_pixel", got, 1);
    chk("one_reads", reads, 1);
    got = 1'b0; k = 0;
    while (!got && k < 2) begin
      @(negedge clk);
      k++;
      if (done1) got = 1'b1;
    end
    chk("one_done", got, 1);
    chk("one_busy_off", busy1, 0);
    @(negedge clk);
    chk("one_done_single", done1, 0);
    chk("one_idle_valid", out_valid1, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    chk("reset_one", {rd_en1, out_valid1, busy1, done1}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Add mode, full throughput, latency and tag placement.
    fill_img();
    img[0] = {8'd250, 8'd5, 8'd128};
    start_frame(8'd10, 1'b0, 0);
    wait_frame("add10");
    chk("first_valid_latency", first_valid_cyc - start_cyc, 2);
    chk("first_accept_edge", first_acc - start_cyc, 2);
    chk("back_to_back", last_acc - first_acc, N - 1);

    // Subtract mode with saturation at zero.
    fill_img();
    img[0] = {8'd5, 8'd10, 8'd200};
    start_frame(8'd10, 1'b1, 0);
    wait_frame("sub10");
    chk("sub_back_to_back", last_acc - first_acc, N - 1);

    // Zero offset passes data through in both modes.
    fill_img();
    start_frame(8'd0, 1'b0, 0);
    wait_frame("pass_add");
    fill_img();
    start_frame(8'd0, 1'b1, 0);
    wait_frame("pass_sub");

    // Back-pressure: ready one cycle in three.
    fill_img();
    start_frame(8'($urandom), 1'($urandom), 1);
    wait_frame("stall");

    // Mid-frame start pulse with a new offset is ignored.
    fill_img();
    start_frame(8'd10, 1'b0, 1);
    repeat (5) @(posedge clk);
    #1;
    start  = 1'b1;
    offset = 8'd50;
    dec    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_frame("restart_ignored");

    // Reset after five accepted pixels aborts the frame.
    fill_img();
    start_frame(8'($urandom), 1'($urandom), 2);
    begin
      int k;
      k = 0;
      while (acc_in_frame < 5 && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      chk("reached_five", acc_in_frame >= 5, 1);
    end
    rst      = 1'b1;
    in_frame = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("abort");
    repeat (4) @(posedge clk);
    #1;
    fill_img();
    start_frame(8'($urandom), 1'($urandom), 0);
    wait_frame("after_abort");

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      fill_img();
      start_frame(8'($urandom), 1'($urandom), $urandom_range(0, 2));
      wait_frame("random");
    end

    // Degenerate 1x1 frame, twice to confirm return to IDLE.
    one_frame(8'd20, 1'b0);
    one_frame(8'($urandom), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
